song_player: RTL and testbench
==============================

SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 SHALL have parameter TICKS_PER_BEAT, default 25_000_000; clk cycles per beat (250 ms at 100 MHz).
REQ-002 SHALL have parameter GAP_TICKS, default 2_500_000; silent cycles after each note, valid range 1..TICKS_PER_BEAT-1.
REQ-003 SHALL have parameter SONG_LEN, default 32; number of song ROM entries.
REQ-004 SHALL have parameter ADDR_W, default 5; ROM address width, with 2**ADDR_W >= SONG_LEN.
REQ-005 SHALL have ports: clk  in  1  system clock; one clock; all state changes on its rising edge.
REQ-006 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: start  in  1  level; begins playback from address 0 when sampled high in IDLE.
REQ-008 SHALL have ports: pause  in  1  level; freezes playback while high.
REQ-009 SHALL have ports: stop  in  1  level; aborts playback.
REQ-010 SHALL have ports: rom_addr  out  ADDR_W  song ROM read address.
REQ-011 SHALL have ports: rom_data  in  6  ROM word {beats_m1[5:4], note[3:0]}; valid one cycle after rom_addr.
REQ-012 SHALL have ports: note  out  4  note code to buzzer; 0 = silence, 1..8 = key 0..7.
REQ-013 SHALL have ports: led  out  8  one-hot key indicator; bit (note-1) set, all zero on rest.
REQ-014 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-015 SHALL have ports: done  out  1  single-cycle pulse at natural song end.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, LOAD, PLAY, GAP, DONE.
REQ-017 SHALL go IDLE->FETCH on start=1, with rom_addr=0; start SHALL be ignored in all other states.
REQ-018 FETCH SHALL hold rom_addr for one cycle, then go to LOAD.
REQ-019 LOAD SHALL latch rom_data: note code and beat count = beats_m1+1 (1..4).
REQ-020 LOAD with note=4'hF (terminator) SHALL go to DONE; all other codes SHALL go to PLAY.
REQ-021 PLAY SHALL last exactly beats*TICKS_PER_BEAT cycles, then go to GAP; the counter width SHALL hold 4*TICKS_PER_BEAT without overflow.
REQ-022 In PLAY, note SHALL equal the latched code for codes 1..8; codes 0 and 9..14 SHALL drive note=0 and led=0 for the full duration.
REQ-023 GAP SHALL last exactly GAP_TICKS cycles with note=0, led=0.
REQ-024 GAP end: if rom_addr==SONG_LEN-1, SHALL go to DONE; else rom_addr SHALL increment by 1 and the FSM SHALL go to FETCH.
REQ-025 DONE SHALL assert done for exactly one cycle, set rom_addr=0, and go to IDLE.
REQ-026 Outputs SHALL be registered; note/led SHALL change in the same cycle the state enters PLAY or GAP.
REQ-027 With pause=1 in PLAY or GAP: the duration counter SHALL freeze, note SHALL be forced to 0, and led SHALL keep its value; on release, the remaining count SHALL resume without loss.
REQ-028 pause SHALL have no effect in IDLE, FETCH, LOAD, DONE.
REQ-029 With stop=1 in any state: the next state SHALL be IDLE, with note=0, led=0, rom_addr=0, and no done pulse.
REQ-030 Priority SHALL be stop > pause > start; with stop and start both high in IDLE, the block SHALL remain in IDLE.
REQ-031 Playback SHALL NOT restart automatically after DONE; a new start is required.

Reset
REQ-032 While rst_n=0, the block SHALL be in IDLE with note=0, led=0, rom_addr=0, busy=0, done=0, and all counters cleared, taking effect asynchronously.
REQ-033 Reset deasserted mid-song SHALL leave the block in IDLE awaiting start; rst_n SHALL be released synchronously to clk.

Verification (TICKS_PER_BEAT=4, GAP_TICKS=1, SONG_LEN=4, bench ROM model with 1-cycle latency)
REQ-034 ROM {6'h01,6'h13,6'h08,6'h05}, start pulse -> note 1 for 4 cycles, 0 for 1; note 3 for 8; 0; note 8 for 4; 0; note 5 for 4; 0; then done pulses once and busy falls.
REQ-035 Entry 1 = 6'h0F -> note 1 for 4 cycles, gap, LOAD of terminator, done pulse; entries 2..3 never addressed.
REQ-036 Entry 0 = 6'h0A (code 10) -> note=0 and led=0 for 4 cycles, then playback continues at address 1.
REQ-037 pause high 3 cycles at PLAY cycle 2 of note 1 -> note=0 and led=8'h01 during pause; note 1 resumes for the remaining 2 cycles; total PLAY time 7 cycles.
REQ-038 stop at PLAY of address 2 -> next cycle IDLE, busy=0, note=0, rom_addr=0, no done; a later start replays from address 0.
REQ-039 rst_n low mid-GAP -> outputs clear without a clk edge; start held high across reset release -> playback begins from address 0.

Source files
------------

// File: rtl/song_player.sv
// Song sequencer: walks a song ROM of {beats_m1, note} words and drives a buzzer
// note code and a one-hot key LED, with pause/stop control and an end-of-song pulse.
module song_player #(
   parameter int TICKS_PER_BEAT = 25_000_000,
   parameter int GAP_TICKS      = 2_500_000,
   parameter int SONG_LEN       = 32,
   parameter int ADDR_W         = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [5:0]        rom_data,
   output logic [3:0]        note,
   output logic [7:0]        led,
   output logic              busy,
   output logic              done
);

   // Wide enough for the longest note (4 beats) without wrapping.
   localparam int CNT_W = $clog2(4 * TICKS_PER_BEAT + 1);

   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
   localparam logic [3:0]        TERM_CODE = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          code_q, code_d;
   logic [3:0]          note_q, note_d;
   logic [7:0]          led_q, led_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Counter preload is one less than the duration: the state ends when it reads zero.
   function automatic logic [CNT_W-1:0] play_load(input logic [1:0] beats_m1);
      case (beats_m1)
         2'd0:    return CNT_W'(TICKS_PER_BEAT - 1);
         2'd1:    return CNT_W'(2 * TICKS_PER_BEAT - 1);
         2'd2:    return CNT_W'(3 * TICKS_PER_BEAT - 1);
         default: return CNT_W'(4 * TICKS_PER_BEAT - 1);
      endcase
   endfunction

   function automatic logic is_key(input logic [3:0] code);
      return (code >= 4'd1) && (code <= 4'd8);
   endfunction

   function automatic logic [3:0] key_note(input logic [3:0] code);
      return is_key(code) ? code : 4'd0;
   endfunction

   function automatic logic [7:0] key_led(input logic [3:0] code);
      return is_key(code) ? (8'd1 << (code - 4'd1)) : 8'd0;
   endfunction

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      note_d  = 4'd0;
      led_d   = 8'd0;
      done_d  = 1'b0;

      if (stop) begin
         state_d = S_IDLE;
         addr_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_FETCH;
                  addr_d  = '0;
               end
            end

            S_FETCH: state_d = S_LOAD;

            S_LOAD: begin
               code_d = rom_data[3:0];
               if (rom_data[3:0] == TERM_CODE) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_PLAY;
                  cnt_d   = play_load(rom_data[5:4]);
                  note_d  = key_note(rom_data[3:0]);
                  led_d   = key_led(rom_data[3:0]);
               end
            end

            S_PLAY: begin
               led_d = led_q;
               if (!pause) begin
                  if (cnt_q == '0) begin
                     state_d = S_GAP;
                     cnt_d   = GAP_LOAD;
                     led_d   = 8'd0;
                  end else begin
                     cnt_d  = cnt_q - 1'b1;
                     note_d = key_note(code_q);
                  end
               end
            end

            S_GAP: begin
               if (!pause) begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - 1'b1;
                  end else if (addr_q == LAST_ADDR) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_FETCH;
                     addr_d  = addr_q + 1'b1;
                  end
               end
            end

            S_DONE: begin
               state_d = S_IDLE;
               addr_d  = '0;
            end

            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: every flop, counters included, is cleared by the async reset so a mid-song
   // reset always lands cleanly in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         code_q  <= 4'd0;
         note_q  <= 4'd0;
         led_q   <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values.
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         note_q  <= note_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign rom_addr = addr_q;
   assign note     = note_q;
   assign led      = led_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player with a 1-cycle-latency ROM model; every cycle of
// each scenario is checked against hand-derived note/led/busy/done/rom_addr values.
module tb_song_player;

   localparam int TPB = 4;
   localparam int GAP = 1;
   localparam int LEN = 4;
   localparam int AW  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          pause;
   logic          stop;
   logic [AW-1:0] rom_addr;
   logic [5:0]    rom_data;
   logic [3:0]    note;
   logic [7:0]    led;
   logic          busy;
   logic          done;

   logic [5:0]    rom [0:LEN-1];
   int            n_checks = 0;
   int            n_fail = 0;
   int            hi_addr_cnt = 0;
   int            snap;

   song_player #(
      .TICKS_PER_BEAT(TPB),
      .GAP_TICKS     (GAP),
      .SONG_LEN      (LEN),
      .ADDR_W        (AW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .pause   (pause),
      .stop    (stop),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .note    (note),
      .led     (led),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   // Counts cycles where the player addresses entries 2 or 3.
   always @(posedge clk) if (busy && rom_addr >= 2'd2) hi_addr_cnt <= hi_addr_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] n, input logic [7:0] l,
                             input logic b, input logic d, input logic [AW-1:0] a);
      check({tag, ".note"}, 32'(note), 32'(n));
      check({tag, ".led"}, 32'(led), 32'(l));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".done"}, 32'(done), 32'(d));
      check({tag, ".addr"}, 32'(rom_addr), 32'(a));
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic cyc(input string tag, input logic [3:0] n, input logic [7:0] l,
                      input logic b, input logic d, input logic [AW-1:0] a);
      expect_out(tag, n, l, b, d, a);
      step();
   endtask

   task automatic seg(input string tag, input int ncyc, input logic [3:0] n,
                      input logic [7:0] l, input logic b, input logic [AW-1:0] a);
      for (int i = 0; i < ncyc; i++) cyc(tag, n, l, b, 1'b0, a);
   endtask

   task automatic play_entry(input string tag, input logic [AW-1:0] a, input logic [3:0] n,
                             input logic [7:0] l, input int cycles);
      cyc({tag, ".fetch"}, 4'd0, 8'd0, 1'b1, 1'b0, a);
      cyc({tag, ".load"}, 4'd0, 8'd0, 1'b1, 1'b0, a);
      seg({tag, ".play"}, cycles, n, l, 1'b1, a);
      cyc({tag, ".gap"}, 4'd0, 8'd0, 1'b1, 1'b0, a);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic load_rom(input logic [5:0] w0, input logic [5:0] w1,
                           input logic [5:0] w2, input logic [5:0] w3);
      rom[0] = w0;
      rom[1] = w1;
      rom[2] = w2;
      rom[3] = w3;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      stop  = 1'b0;
      load_rom(6'h01, 6'h13, 6'h08, 6'h05);
      #1 rst_n = 1'b0;
      #1 expect_out("rst_async", 4'd0, 8'd0, 1'b0, 1'b0, 2'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      cyc("idle_after_rst", 4'd0, 8'd0, 1'b0, 1'b0, 2'd0);

      // Full four-note song with a two-beat second note.
      pulse_start();
      play_entry("s1.e0", 2'd0, 4'd1, 8'h01, 4);
      play_entry("s1.e1", 2'd1, 4'd3, 8'h04, 8);
      play_entry("s1.e2", 2'd2, 4'd8, 8'h80, 4);
      play_entry("s1.e3", 2'd3, 4'd5, 8'h10, 4);
      cyc("s1.done", 4'd0, 8'd0, 1'b1, 1'b1, 2'd3);
      seg("s1.idle", 3, 4'd0, 8'd0, 1'b0, 2'd0);

      // Terminator at entry 1 ends the song early.
      load_rom(6'h01, 6'h0F, 6'h01, 6'h01);
      snap = hi_addr_cnt;
      pulse_start();
      play_entry("s2.e0", 2'd0, 4'd1, 8'h01, 4);
      cyc("s2.fetch1", 4'd0, 8'd0, 1'b1, 1'b0, 2'd1);
      cyc("s2.load_term", 4'd0, 8'd0, 1'b1, 1'b0, 2'd1);
      cyc("s2.done", 4'd0, 8'd0, 1'b1, 1'b1, 2'd1);
      seg("s2.idle", 2, 4'd0, 8'd0, 1'b0, 2'd0);
      check("s2.no_hi_addr", hi_addr_cnt - snap, 0);

      // Out-of-range note code plays as a rest; terminator on the last entry.
      load_rom(6'h0A, 6'h01, 6'h02, 6'h0F);
      pulse_start();
      play_entry("s3.e0_rest", 2'd0, 4'd0, 8'h00, 4);
      play_entry("s3.e1", 2'd1, 4'd1, 8'h01, 4);
      play_entry("s3.e2", 2'd2, 4'd2, 8'h02, 4);
      cyc("s3.fetch3", 4'd0, 8'd0, 1'b1, 1'b0, 2'd3);
      cyc("s3.load_term", 4'd0, 8'd0, 1'b1, 1'b0, 2'd3);
      cyc("s3.done", 4'd0, 8'd0, 1'b1, 1'b1, 2'd3);
      cyc("s3.idle", 4'd0, 8'd0, 1'b0, 1'b0, 2'd0);

      // Pause for three cycles from PLAY cycle 2: note mutes, led holds, count resumes.
      load_rom(6'h01, 6'h0F, 6'h00, 6'h00);
      pulse_start();
      cyc("s4.fetch", 4'd0, 8'd0, 1'b1, 1'b0, 2'd0);
      cyc("s4.load", 4'd0, 8'd0, 1'b1, 1'b0, 2'd0);
      cyc("s4.play1", 4'd1, 8'h01, 1'b1, 1'b0, 2'd0);
      expect_out("s4.play2", 4'd1, 8'h01, 1'b1, 1'b0, 2'd0);
      pause = 1'b1;
      step();
      seg("s4.paused", 2, 4'd0, 8'h01, 1'b1, 2'd0);
      expect_out("s4.paused_last", 4'd0, 8'h01, 1'b1, 1'b0, 2'd0);
      pause = 1'b0;
      step();
      seg("s4.resume", 2, 4'd1, 8'h01, 1'b1, 2'd0);
      cyc("s4.gap", 4'd0, 8'd0, 1'b1, 1'b0, 2'd0);
      cyc("s4.fetch1", 4'd0, 8'd0, 1'b1, 1'b0, 2'd1);
      cyc("s4.load_term", 4'd0, 8'd0, 1'b1, 1'b0, 2'd1);
      cyc("s4.done", 4'd0, 8'd0, 1'b1, 1'b1, 2'd1);
      cyc("s4.idle", 4'd0, 8'd0, 1'b0, 1'b0, 2'd0);

      // Stop while playing entry 2, stop beats start in IDLE, then replay from 0.
      load_rom(6'h01, 6'h02, 6'h03, 6'h04);
      pulse_start();
      play_entry("s5.e0", 2'd0, 4'd1, 8'h01, 4);
      play_entry("s5.e1", 2'd1, 4'd2, 8'h02, 4);
      cyc("s5.fetch2", 4'd0, 8'd0, 1'b1, 1'b0, 2'd2);
      cyc("s5.load2", 4'd0, 8'd0, 1'b1, 1'b0, 2'd2);
      expect_out("s5.play2", 4'd3, 8'h04, 1'b1, 1'b0, 2'd2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      cyc("s5.stopped", 4'd0, 8'd0, 1'b0, 1'b0, 2'd0);
      seg("s5.idle", 2, 4'd0, 8'd0, 1'b0, 2'd0);
      stop  = 1'b1;
      start = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b0;
      cyc("s5.stop_over_start", 4'd0, 8'd0, 1'b0, 1'b0, 2'd0);
      pulse_start();
      cyc("s5.re_fetch", 4'd0, 8'd0, 1'b1, 1'b0, 2'd0);
      cyc("s5.re_load", 4'd0, 8'd0, 1'b1, 1'b0, 2'd0);
      expect_out("s5.re_play", 4'd1, 8'h01, 1'b1, 1'b0, 2'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      cyc("s5.re_stopped", 4'd0, 8'd0, 1'b0, 1'b0, 2'd0);

      // Async reset in the GAP of entry 1; start held across release restarts at 0.
      load_rom(6'h01, 6'h02, 6'h0F, 6'h0F);
      pulse_start();
      play_entry("s6.e0", 2'd0, 4'd1, 8'h01, 4);
      cyc("s6.fetch1", 4'd0, 8'd0, 1'b1, 1'b0, 2'd1);
      cyc("s6.load1", 4'd0, 8'd0, 1'b1, 1'b0, 2'd1);
      seg("s6.play1", 4, 4'd2, 8'h02, 1'b1, 2'd1);
      expect_out("s6.gap1", 4'd0, 8'd0, 1'b1, 1'b0, 2'd1);
      #2 rst_n = 1'b0;
      #1 expect_out("s6.rst_async", 4'd0, 8'd0, 1'b0, 1'b0, 2'd0);
      start = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      cyc("s6.fetch0", 4'd0, 8'd0, 1'b1, 1'b0, 2'd0);
      start = 1'b0;
      cyc("s6.load0", 4'd0, 8'd0, 1'b1, 1'b0, 2'd0);
      expect_out("s6.play0", 4'd1, 8'h01, 1'b1, 1'b0, 2'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      cyc("s6.stopped", 4'd0, 8'd0, 1'b0, 1'b0, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
